// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C register-LUT configuration sequencer.
// State encoding, LUT marker codes and error-counter sizing.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WRITE,
    ST_READ,
    ST_DELAY,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam logic [7:0] END_MARK   = 8'hFF;
  localparam logic [7:0] DELAY_MARK = 8'hFE;

  localparam int ERR_CW = 8;

  function automatic logic [ERR_CW-1:0] sat_inc(
    input logic [ERR_CW-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/i2c_cfg_delay_timer.sv
// Loadable down-counter used for timed-delay LUT entries.
// Loading N keeps expired_o low for N enabled cycles.
module i2c_cfg_delay_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_config_seq.sv
// Walks a register LUT and issues I2C writes (optional read-back verify),
// with bounded retry, timed delays and error reporting.
module i2c_config_seq
  import i2c_cfg_pkg::*;
#(
  parameter int LUT_AW      = 10,
  parameter int LUT_LAT     = 1,
  parameter int MAX_RETRY   = 2,
  parameter int VERIFY      = 0,
  parameter int DELAY_TICKS = 50000,
  parameter int AUTO_START  = 1,
  parameter int STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [LUT_AW-1:0] lut_index,
  input  logic [7:0]        lut_dev_addr,
  input  logic [15:0]       lut_reg_addr,
  input  logic [7:0]        lut_reg_data,
  input  logic              lut_addr_2byte,
  output logic              mst_write_req,
  output logic              mst_read_req,
  input  logic              mst_req_ack,
  input  logic              mst_error,
  input  logic [7:0]        mst_read_data,
  output logic [7:0]        mst_dev_addr,
  output logic [15:0]       mst_reg_addr,
  output logic [7:0]        mst_write_data,
  output logic              mst_addr_2byte,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LUT_AW-1:0] err_index,
  output logic [7:0]        err_count
);

  localparam int DW = $clog2(255 * DELAY_TICKS + 1);

  state_e              state_q;
  logic [LUT_AW-1:0]   idx_q;
  logic [LUT_AW-1:0]   err_idx_q;
  logic [ERR_CW-1:0]   err_cnt_q;
  logic [1:0]          lat_q;
  logic [2:0]          retry_q;
  logic                auto_q;
  logic                wr_q;
  logic                rd_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [7:0]          dev_q;
  logic [15:0]         ra_q;
  logic [7:0]          wd_q;
  logic                two_q;

  logic                can_retry;
  logic                wr_bad;
  logic                rd_bad;
  logic                tmr_load;
  logic                tmr_exp;
  logic [DW-1:0]       tmr_val;

  assign can_retry = retry_q < 3'(MAX_RETRY);
  assign wr_bad = (state_q == ST_WRITE) && wr_q
                  && mst_req_ack && mst_error;
  assign rd_bad = (state_q == ST_READ) && rd_q && mst_req_ack
                  && (mst_error || mst_read_data != wd_q);

  // Timer holds N-1 so DELAY lasts exactly N cycles.
  assign tmr_load = (state_q == ST_DECODE)
                    && (lut_dev_addr == DELAY_MARK)
                    && (lut_reg_data != '0);
  assign tmr_val = DW'(lut_reg_data) * DW'(DELAY_TICKS) - DW'(1);

  i2c_cfg_delay_timer #(
    .W (DW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .value_i   (tmr_val),
    .en_i      (state_q == ST_DELAY),
    .expired_o (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      err_cnt_q <= '0;
      lat_q     <= '0;
      retry_q   <= '0;
      auto_q    <= (AUTO_START != 0);
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      dev_q     <= '0;
      ra_q      <= '0;
      wd_q      <= '0;
      two_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          auto_q <= 1'b0;
          if (start || auto_q) begin
            state_q   <= ST_FETCH;
            idx_q     <= '0;
            lat_q     <= '0;
            retry_q   <= '0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            err_cnt_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (lat_q == 2'(LUT_LAT)) begin
            state_q <= ST_DECODE;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        ST_DECODE: begin
          unique case (1'b1)
            lut_dev_addr == END_MARK: begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
            lut_dev_addr == DELAY_MARK: begin
              state_q <= (lut_reg_data == '0) ? ST_NEXT : ST_DELAY;
            end
            default: begin
              dev_q   <= lut_dev_addr;
              ra_q    <= lut_reg_addr;
              wd_q    <= lut_reg_data;
              two_q   <= lut_addr_2byte;
              wr_q    <= 1'b1;
              state_q <= ST_WRITE;
            end
          endcase
        end
        ST_WRITE: begin
          if (!wr_q) begin
            wr_q <= 1'b1;
          end else if (mst_req_ack) begin
            wr_q <= 1'b0;
            if (!mst_error) begin
              if (VERIFY != 0) begin
                rd_q    <= 1'b1;
                state_q <= ST_READ;
              end else begin
                state_q <= ST_NEXT;
              end
            end
          end
        end
        ST_READ: begin
          if (rd_q && mst_req_ack) begin
            rd_q <= 1'b0;
            if (!rd_bad) begin
              state_q <= ST_NEXT;
            end
          end
        end
        ST_DELAY: begin
          if (tmr_exp) begin
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          retry_q <= '0;
          if (idx_q == '1) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            lat_q   <= '0;
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Retry re-enters WRITE with the request low; WRITE re-raises it.
      if (wr_bad || rd_bad) begin
        if (can_retry) begin
          retry_q <= retry_q + 1'b1;
          state_q <= ST_WRITE;
        end else begin
          error_q   <= 1'b1;
          err_cnt_q <= sat_inc(err_cnt_q);
          if (!error_q) begin
            err_idx_q <= idx_q;
          end
          if (STOP_ON_ERR != 0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_NEXT;
          end
        end
      end
    end
  end

  assign lut_index      = idx_q;
  assign mst_write_req  = wr_q;
  assign mst_read_req   = rd_q;
  assign mst_dev_addr   = dev_q;
  assign mst_reg_addr   = ra_q;
  assign mst_write_data = wd_q;
  assign mst_addr_2byte = two_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_index      = err_idx_q;
  assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Scoreboard bench: directed LUT programs, a behavioural I2C master
// and a monitor that checks each request against queued expectations.
module tb_i2c_config_seq;

  localparam int AW      = 3;
  localparam int ACK_DLY = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] lut_index;
  logic [7:0]    lut_dev_addr;
  logic [15:0]   lut_reg_addr;
  logic [7:0]    lut_reg_data;
  logic          lut_addr_2byte;
  logic          mst_write_req;
  logic          mst_read_req;
  logic          mst_req_ack = 1'b0;
  logic          mst_error = 1'b0;
  logic [7:0]    mst_read_data = 8'h00;
  logic [7:0]    mst_dev_addr;
  logic [15:0]   mst_reg_addr;
  logic [7:0]    mst_write_data;
  logic          mst_addr_2byte;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] err_index;
  logic [7:0]    err_count;

  i2c_config_seq #(
    .LUT_AW      (AW),
    .LUT_LAT     (1),
    .MAX_RETRY   (2),
    .VERIFY      (1),
    .DELAY_TICKS (10),
    .AUTO_START  (0),
    .STOP_ON_ERR (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .lut_index      (lut_index),
    .lut_dev_addr   (lut_dev_addr),
    .lut_reg_addr   (lut_reg_addr),
    .lut_reg_data   (lut_reg_data),
    .lut_addr_2byte (lut_addr_2byte),
    .mst_write_req  (mst_write_req),
    .mst_read_req   (mst_read_req),
    .mst_req_ack    (mst_req_ack),
    .mst_error      (mst_error),
    .mst_read_data  (mst_read_data),
    .mst_dev_addr   (mst_dev_addr),
    .mst_reg_addr   (mst_reg_addr),
    .mst_write_data (mst_write_data),
    .mst_addr_2byte (mst_addr_2byte),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_index      (err_index),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  logic [7:0]  rom_dev [8];
  logic [15:0] rom_reg [8];
  logic [7:0]  rom_dat [8];
  logic        rom_two [8];

  assign lut_dev_addr   = rom_dev[lut_index];
  assign lut_reg_addr   = rom_reg[lut_index];
  assign lut_reg_data   = rom_dat[lut_index];
  assign lut_addr_2byte = rom_two[lut_index];

  typedef struct packed {
    logic        rd;
    logic [7:0]  dev;
    logic [15:0] ra;
    logic [7:0]  d;
    logic        two;
  } req_t;

  req_t exp_q[$];
  int   rise_t[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  int         nack_left[int];
  logic [7:0] rdx[int];
  logic [7:0] mem[int];

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 8; i++) begin
      rom_dev[i] = 8'hFF;
      rom_reg[i] = 16'h0;
      rom_dat[i] = 8'h0;
      rom_two[i] = 1'b0;
    end
    nack_left.delete();
    rdx.delete();
    rise_t.delete();
  endtask

  task automatic set_rom(int i, logic [7:0] dv, logic [15:0] ra,
                         logic [7:0] d, logic two);
    rom_dev[i] = dv;
    rom_reg[i] = ra;
    rom_dat[i] = d;
    rom_two[i] = two;
  endtask

  task automatic exp_w(int i);
    exp_q.push_back('{1'b0, rom_dev[i], rom_reg[i], rom_dat[i],
                      rom_two[i]});
  endtask

  task automatic exp_r(int i);
    exp_q.push_back('{1'b1, rom_dev[i], rom_reg[i], rom_dat[i],
                      rom_two[i]});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_seq(string nm, int idx, int err, int eidx,
                         int ecnt);
    int n;
    pulse_start();
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_index"}, lut_index, idx);
    chk({nm, "_error"}, error, err);
    chk({nm, "_err_index"}, err_index, eidx);
    chk({nm, "_err_count"}, err_count, ecnt);
    chk({nm, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Behavioural I2C master: acks ACK_DLY cycles after a request.
  logic        m_rd;
  logic [15:0] m_ra;
  logic [7:0]  m_wd;
  always begin
    @(negedge clk);
    if (rst && (mst_write_req || mst_read_req)) begin
      m_rd = mst_read_req;
      m_ra = mst_reg_addr;
      m_wd = mst_write_data;
      repeat (ACK_DLY) @(negedge clk);
      mst_req_ack   = 1'b1;
      mst_error     = 1'b0;
      mst_read_data = 8'h00;
      if (!m_rd) begin
        if (nack_left.exists(int'(m_ra)) && nack_left[int'(m_ra)] > 0) begin
          mst_error = 1'b1;
          nack_left[int'(m_ra)] = nack_left[int'(m_ra)] - 1;
        end else begin
          mem[int'(m_ra)] = m_wd;
        end
      end else begin
        mst_read_data = mem.exists(int'(m_ra)) ? mem[int'(m_ra)] : 8'h00;
        if (rdx.exists(int'(m_ra)))
          mst_read_data = mst_read_data ^ rdx[int'(m_ra)];
      end
      @(negedge clk);
      mst_req_ack = 1'b0;
      mst_error   = 1'b0;
    end
  end

  // Monitor: every new request is popped against the scoreboard.
  logic pw = 1'b0;
  logic pr = 1'b0;
  req_t got;
  req_t ex;
  always @(negedge clk) begin
    cyc++;
    if (mst_write_req || mst_read_req)
      chk("req_exclusive", mst_write_req && mst_read_req, 0);
    if ((mst_write_req && !pw) || (mst_read_req && !pr)) begin
      got = '{mst_read_req, mst_dev_addr, mst_reg_addr,
              mst_write_data, mst_addr_2byte};
      rise_t.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_req: got %0h expected none", got);
      end else begin
        ex = exp_q.pop_front();
        chk("req", got, ex);
      end
    end
    pw = mst_write_req;
    pr = mst_read_req;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  int g0, g1, g3, n;

  initial begin
    clear_rom();
    #1;
    chk("rst_flags", {busy, done, error, mst_write_req, mst_read_req}, 0);
    chk("rst_index", lut_index, 0);
    chk("rst_err", {err_index, err_count}, 0);
    chk("rst_mst", {mst_dev_addr, mst_reg_addr, mst_write_data,
                    mst_addr_2byte}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_autostart", {busy, done}, 0);

    // Three plain writes with read-back
    clear_rom();
    set_rom(0, 8'h42, 16'h3008, 8'h11, 1'b1);
    set_rom(1, 8'h42, 16'h3103, 8'h22, 1'b1);
    set_rom(2, 8'h42, 16'h3017, 8'h33, 1'b1);
    for (int i = 0; i < 3; i++) begin exp_w(i); exp_r(i); end
    run_seq("basic", 3, 0, 0, 0);

    // Two NACKs then success on entry 1
    clear_rom();
    set_rom(0, 8'h42, 16'h3008, 8'h11, 1'b1);
    set_rom(1, 8'h42, 16'h3103, 8'h22, 1'b1);
    set_rom(2, 8'h42, 16'h3017, 8'h33, 1'b1);
    nack_left[16'h3103] = 2;
    exp_w(0); exp_r(0);
    exp_w(1); exp_w(1); exp_w(1); exp_r(1);
    exp_w(2); exp_r(2);
    run_seq("retry_ok", 3, 0, 0, 0);

    // Entry 1 always NACKs: fails, sequence continues
    clear_rom();
    set_rom(0, 8'h42, 16'h3008, 8'h11, 1'b1);
    set_rom(1, 8'h42, 16'h3103, 8'h22, 1'b1);
    set_rom(2, 8'h42, 16'h3017, 8'h33, 1'b1);
    nack_left[16'h3103] = 1000;
    exp_w(0); exp_r(0);
    exp_w(1); exp_w(1); exp_w(1);
    exp_w(2); exp_r(2);
    run_seq("nack_fail", 3, 1, 1, 1);

    // Read-back mismatch on entries 1 and 2; first index latched
    clear_rom();
    set_rom(0, 8'h42, 16'h3008, 8'h11, 1'b1);
    set_rom(1, 8'h42, 16'h3103, 8'h5A, 1'b1);
    set_rom(2, 8'h42, 16'h3017, 8'h33, 1'b0);
    rdx[16'h3103] = 8'h01;
    rdx[16'h3017] = 8'h80;
    exp_w(0); exp_r(0);
    for (int k = 0; k < 3; k++) begin exp_w(1); exp_r(1); end
    for (int k = 0; k < 3; k++) begin exp_w(2); exp_r(2); end
    run_seq("verify_fail", 3, 1, 1, 2);

    // Delay entries of 0, 1 and 3 units (10 cycles each)
    for (int k = 0; k < 3; k++) begin
      clear_rom();
      set_rom(0, 8'h50, 16'h0001, 8'hA1, 1'b0);
      set_rom(1, 8'hFE, 16'h0000, (k == 0) ? 8'd0 : (k == 1) ? 8'd1 : 8'd3,
              1'b0);
      set_rom(2, 8'h50, 16'h0002, 8'hA2, 1'b1);
      exp_w(0); exp_r(0); exp_w(2); exp_r(2);
      run_seq("delay", 3, 0, 0, 0);
      n = (rise_t.size() >= 3) ? rise_t[2] - rise_t[1] : 0;
      if (k == 0) g0 = n;
      else if (k == 1) g1 = n;
      else g3 = n;
    end
    chk("delay_1unit", g1 - g0, 10);
    chk("delay_3unit", g3 - g0, 30);

    // Full LUT without an end marker: stops at the last index
    clear_rom();
    for (int i = 0; i < 8; i++) begin
      set_rom(i, 8'h30 + 8'(i), 16'(i * 257), 8'(i * 16 + 1), i[0]);
      exp_w(i); exp_r(i);
    end
    run_seq("full_lut", 7, 0, 0, 0);

    // Reset in the middle of a write
    clear_rom();
    set_rom(0, 8'h42, 16'h3008, 8'h11, 1'b1);
    set_rom(1, 8'h42, 16'h3103, 8'h22, 1'b1);
    set_rom(2, 8'h42, 16'h3017, 8'h33, 1'b1);
    exp_w(0);
    pulse_start();
    n = 0;
    while (!mst_write_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_write_seen", mst_write_req, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", {mst_write_req, mst_read_req}, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle_after_rst", {busy, done}, 0);

    // Restart by pulse; a second start while busy is ignored
    for (int i = 0; i < 3; i++) begin exp_w(i); exp_r(i); end
    fork
      run_seq("restart", 3, 0, 0, 0);
      begin
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
